// File: rtl/cactus_gen_pkg.sv
// Shared game constants, mode encoding and small helpers for the cactus generator.
// The optional CACTUS_RANDOM_EN build uses lfsr_next() for randomised spawn gaps.
package cactus_gen_pkg;

   localparam int H_DISP    = 800;
   localparam int V_DISP    = 480;
   localparam int GROUND_Y  = 400;
   localparam int CACTUS_W  = 20;
   localparam int CACTUS_H  = 40;
   localparam int MIN_GAP   = 40;
   localparam int GAP_FIXED = MIN_GAP + 32;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_PLAY = 2'd1,
      MODE_OVER = 2'd2
   } game_mode_e;

   // Fibonacci LFSR, taps 16,14,13,11
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {7'd0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/cactus_slot.sv
// One cactus slot: position/active state, move-retire-spawn update and
// registered per-pixel coverage flag.
module cactus_slot
   import cactus_gen_pkg::*;
(
   input  logic        lcd_pclk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        move_i,
   input  logic        spawn_i,
   input  logic [3:0]  move_rate_i,
   input  logic [10:0] px_i,
   input  logic [10:0] py_i,
   output logic        active_o,
   output logic        retire_o,
   output logic        draw_o
);

   localparam logic signed [11:0] X_SPAWN  = 12'(H_DISP);
   localparam logic signed [11:0] X_RETIRE = 12'(-CACTUS_W);
   localparam logic signed [11:0] W12      = 12'(CACTUS_W);
   localparam logic signed [11:0] Y_TOP    = 12'(GROUND_Y - CACTUS_H);
   localparam logic signed [11:0] Y_BOT    = 12'(GROUND_Y);

   logic              active_q, active_d;
   logic signed [11:0] x_q, x_d;
   logic              draw_q, draw_d;
   logic signed [11:0] x_mov, px_s, py_s;

   always_comb begin
      x_mov    = x_q - $signed({8'd0, move_rate_i});
      retire_o = move_i && active_q && (x_mov <= X_RETIRE);
      px_s     = $signed({1'b0, px_i});
      py_s     = $signed({1'b0, py_i});
      // off-screen columns simply never match a pixel coordinate
      draw_d   = active_q && (px_s >= x_q) && (px_s < x_q + W12)
                 && (py_s >= Y_TOP) && (py_s < Y_BOT);

      active_d = active_q;
      x_d      = x_q;
      if (clear_i) begin
         active_d = 1'b0;
      end else if (spawn_i) begin
         active_d = 1'b1;
         x_d      = X_SPAWN;
      end else if (move_i && active_q) begin
         x_d = x_mov;
         if (retire_o) active_d = 1'b0;
      end
   end

   always_ff @(posedge lcd_pclk) begin
      if (rst) begin
         active_q <= 1'b0;
         x_q      <= '0;
         draw_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         draw_q   <= draw_d;
      end
   end

   assign active_o = active_q;
   assign draw_o   = draw_q;

endmodule

// File: rtl/cactus_gen.sv
// Cactus obstacle generator: frame tick, spawn gap timer, two scrolling slots.
// Define CACTUS_RANDOM_EN for LFSR-randomised gaps; otherwise the gap is fixed.
module cactus_gen
   import cactus_gen_pkg::*;
(
   input  logic        lcd_pclk,
   input  logic        rst,
   input  logic [10:0] pixel_xpos,
   input  logic [10:0] pixel_ypos,
   input  logic        is_living,
   input  logic        is_dying,
   input  logic [3:0]  move_rate,
   output logic        cactus_draw,
   output logic        cactus_draw_2,
   output logic [7:0]  passed_cnt
);

   game_mode_e  mode;
   logic        frame_tick, live_tick, idle_tick;
   logic        act0, act1, retire0, retire1, spawn0, spawn1;
   logic [6:0]  gap_q, gap_d, gap_load;
   logic [7:0]  passed_q, passed_d;

`ifdef CACTUS_RANDOM_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge lcd_pclk) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_next(lfsr_q);
   end

   assign gap_load = 7'(MIN_GAP) + {1'b0, lfsr_q[5:0]};
`else
   assign gap_load = 7'(GAP_FIXED);
`endif

   always_comb begin
      frame_tick = (pixel_xpos == 11'(H_DISP - 1)) && (pixel_ypos == 11'(V_DISP - 1));
      mode = MODE_IDLE;
      if (is_dying)       mode = MODE_OVER;
      else if (is_living) mode = MODE_PLAY;
      live_tick = frame_tick && (mode == MODE_PLAY);
      idle_tick = frame_tick && (mode == MODE_IDLE);

      // slot 0 wins; a slot freed this tick is only eligible next tick
      spawn0 = live_tick && (gap_q == 7'd0) && !act0;
      spawn1 = live_tick && (gap_q == 7'd0) && act0 && !act1;

      gap_d = gap_q;
      if (idle_tick) begin
         gap_d = 7'(MIN_GAP);
      end else if (live_tick) begin
         if (gap_q != 7'd0)        gap_d = gap_q - 7'd1;
         else if (spawn0 || spawn1) gap_d = gap_load;
      end

      passed_d = sat_add8(passed_q, {1'b0, retire0} + {1'b0, retire1});
   end

   always_ff @(posedge lcd_pclk) begin
      if (rst) begin
         gap_q    <= 7'(MIN_GAP);
         passed_q <= 8'd0;
      end else begin
         gap_q    <= gap_d;
         passed_q <= passed_d;
      end
   end

   cactus_slot u_slot0 (
      .lcd_pclk    (lcd_pclk),
      .rst         (rst),
      .clear_i     (idle_tick),
      .move_i      (live_tick),
      .spawn_i     (spawn0),
      .move_rate_i (move_rate),
      .px_i        (pixel_xpos),
      .py_i        (pixel_ypos),
      .active_o    (act0),
      .retire_o    (retire0),
      .draw_o      (cactus_draw)
   );

   cactus_slot u_slot1 (
      .lcd_pclk    (lcd_pclk),
      .rst         (rst),
      .clear_i     (idle_tick),
      .move_i      (live_tick),
      .spawn_i     (spawn1),
      .move_rate_i (move_rate),
      .px_i        (pixel_xpos),
      .py_i        (pixel_ypos),
      .active_o    (act1),
      .retire_o    (retire1),
      .draw_o      (cactus_draw_2)
   );

   assign passed_cnt = passed_q;

endmodule
